counter_cfg_sched: RTL and testbench
====================================

Name: counter_cfg_sched

Overview:
- Shares the 3-channel down-counter's write port among three requesters (CPU bus, polling engine, debug) using round-robin arbitration.
- Each granted request is sequenced as two counter writes: control word (channel 3), then load value (channel 0–2).
- Keeps a shadow copy of the counter control word so one channel's mode change never disturbs the other channels.
- Synchronises the three counter OUT bits into clk and latches terminal-count flags with an interrupt line.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on each counterN_OUT synchroniser (legal 2..3).
- CTRL_INIT, 24'h000000: shadow control word value after reset; matches counter control reset.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  3  request per requester r (bit r); held high until ack[r]
- req_ch  in  6  channel for requester r at [2r+1:2r]
- req_mode  in  6  mode for requester r at [2r+1:2r] (00 one-shot, 01 reload, 10 square, 11 free-run)
- req_val  in  96  load value for requester r at [32r+31:32r]
- ack  out  3  one-cycle completion pulse per requester
- err  out  1  valid with ack; 1 = request rejected (req_ch==3)
- busy  out  1  high whenever state != IDLE
- counter_we  out  1  write strobe to counter
- counter_ch  out  2  write channel to counter
- counter_val  out  32  write data to counter
- counter0_OUT, counter1_OUT, counter2_OUT  in  1 each  counter MSB outputs, from foreign clock domains
- tc_flag  out  3  sticky terminal-count flags, one per channel
- tc_clr  in  3  clears the corresponding tc_flag bit
- irq  out  1  OR of tc_flag

Behaviour:
- Reset (async): state IDLE, rr_ptr=0, shadow=CTRL_INIT, tc_flag=0, synchronisers=0.
- Reset values of outputs: ack=0, err=0, busy=0, counter_we=0, counter_ch=0, counter_val=0, tc_flag=0, irq=0.
- Reset mid-sequence: the sequence is abandoned, no ack is issued, and no further writes occur.
- FSM states: IDLE, WCTRL, WLOCK, DONE.
- IDLE:
  - If any req bit is high, grant the first requester at or after rr_ptr (cyclic order rr_ptr, rr_ptr+1, ...).
  - Latch the grantee's ch, mode and val; set rr_ptr = grantee+1 mod 3.
  - If ch==3, go to DONE with err=1. Otherwise compute the new shadow and go to WCTRL.
- New shadow field per channel: ch0 bits [2:1], ch1 bits [10:9], ch2 bits [18:17]. All other bits are unchanged.
- WCTRL (1 cycle): counter_we=1, counter_ch=3, counter_val={8'h00, new shadow}. The shadow register updates this cycle. Next state WLOCK.
- WLOCK (1 cycle): counter_we=1, counter_ch=latched ch, counter_val=latched val. Clears tc_flag[ch]. Next state DONE.
- DONE (1 cycle): ack[grantee]=1, err as determined. Next state IDLE.
- Latency: request seen in IDLE at cycle 0 gives WCTRL at cycle 1, WLOCK at cycle 2, ack at cycle 3. Rejected request: ack+err at cycle 1.
- counter_we is 0 in IDLE and DONE; counter_ch and counter_val are driven 0 when counter_we=0.
- Requests arriving or deasserting while busy are ignored until IDLE. A requester must not drop req before ack; if it does, the sequence still completes.
- Minimum spacing between grants is 4 cycles, since IDLE is re-entered after DONE.
- Terminal-count path per channel:
  - SYNC_STAGES-flop synchroniser, then a rising-edge detector on the synchronised value.
  - A rising edge sets tc_flag[n]; tc_clr[n] or a WLOCK write to channel n clears it.
  - Set and clear in the same cycle: set wins.
- irq = |tc_flag, registered path only (no combinational path from inputs).
- Values: no arithmetic on val; 32-bit pass-through. Shadow bits [23:19], [16:11], [8:3], [0] are preserved as CTRL_INIT.

Test Plan:
- Reset, then req=3'b001, ch=0, mode=01, val=32'd100:
  - cycle 1: we=1, ch=3, val=32'h00000002
  - cycle 2: we=1, ch=0, val=100
  - cycle 3: ack=3'b001, err=0
- Requester 1 sets ch2 mode 10 after the above:
  - WCTRL val=32'h00040002 (ch0 field kept)
  - shadow read back unchanged for ch0/ch1
- req=3'b111 held continuously, rr_ptr=0:
  - grant order 0,1,2,0
  - acks 4 cycles apart
  - no requester starved
- req_ch=3 from requester 2 → ack=3'b100 with err=1 at cycle 1; counter_we never asserted.
- counter1_OUT toggles 0→1 asynchronously → tc_flag=3'b010 and irq=1 within SYNC_STAGES+1 cycles; tc_clr=3'b010 pulse → flag 0.
- tc_clr[0] and a synchronised rising edge of ch0 in the same cycle → tc_flag[0]=1.
- Assert rst during WLOCK → outputs 0 immediately, no ack; next request is sequenced normally with shadow=0-based word.

Source files
------------

// File: rtl/counter_cfg_sched_if.sv
// Request bus shared by the three counter-configuration requesters
// (CPU bus, polling engine, debug). The master side drives requests,
// the slave side (the scheduler) returns completion and status.
interface counter_cfg_sched_if;
  logic [2:0]  req;
  logic [5:0]  req_ch;
  logic [5:0]  req_mode;
  logic [95:0] req_val;
  logic [2:0]  ack;
  logic        err;
  logic        busy;

  modport master (
    output req, req_ch, req_mode, req_val,
    input  ack, err, busy
  );

  modport slave (
    input  req, req_ch, req_mode, req_val,
    output ack, err, busy
  );
endinterface

// File: rtl/counter_cfg_sched.sv
// Round-robin scheduler for the 3-channel down-counter write port.
// Each grant becomes a control-word write (channel 3) built from a shadow
// copy, followed by the load-value write. Also synchronises the counter
// OUT bits and keeps sticky terminal-count flags with an interrupt.
//
//   state | meaning
//   IDLE  | waiting for a request, arbitrates when any req is high
//   WCTRL | writing merged control word to channel 3, shadow updates
//   WLOCK | writing load value to the granted channel, clears its tc_flag
//   DONE  | ack pulse to the grantee, err if the channel was 3
module counter_cfg_sched #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [23:0] CTRL_INIT   = 24'h000000
) (
  input  logic                 clk,
  input  logic                 rst,
  counter_cfg_sched_if.slave   bus,
  output logic                 counter_we,
  output logic [1:0]           counter_ch,
  output logic [31:0]          counter_val,
  input  logic                 counter0_OUT,
  input  logic                 counter1_OUT,
  input  logic                 counter2_OUT,
  output logic [2:0]           tc_flag,
  input  logic [2:0]           tc_clr,
  output logic                 irq
);

  typedef enum logic [1:0] {IDLE, WCTRL, WLOCK, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  rr_ptr;
  logic [1:0]  g_idx;
  logic [1:0]  g_ch;
  logic [1:0]  g_mode;
  logic [31:0] g_val;
  logic        g_err;
  logic [23:0] shadow;
  logic [23:0] shadow_new;

  logic        gnt_valid;
  logic [1:0]  gnt_idx;
  logic [1:0]  gnt_ch;
  logic [1:0]  gnt_mode;
  logic [31:0] gnt_val;
  logic [1:0]  cand;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Round-robin pick: first requester at or after rr_ptr, cyclically.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 2'd0;
    cand      = rr_ptr;
    for (int k = 0; k < 3; k++) begin
      if (!gnt_valid && bus.req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
      cand = inc3(cand);
    end
    gnt_ch   = bus.req_ch[{gnt_idx, 1'b0} +: 2];
    gnt_mode = bus.req_mode[{gnt_idx, 1'b0} +: 2];
    gnt_val  = bus.req_val[{gnt_idx, 5'b00000} +: 32];
  end

  // Merge the latched mode into only the granted channel's control field.
  always_comb begin
    shadow_new = shadow;
    case (g_ch)
      2'd0:    shadow_new[2:1]   = g_mode;
      2'd1:    shadow_new[10:9]  = g_mode;
      2'd2:    shadow_new[18:17] = g_mode;
      default: shadow_new        = shadow;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and Moore outputs; write bus is zero unless strobed.
  always_comb begin
    state_d     = state_q;
    counter_we  = 1'b0;
    counter_ch  = 2'd0;
    counter_val = 32'd0;
    bus.ack     = 3'b000;
    bus.err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) state_d = (gnt_ch == 2'd3) ? DONE : WCTRL;
      end
      WCTRL: begin
        counter_we  = 1'b1;
        counter_ch  = 2'd3;
        counter_val = {8'h00, shadow_new};
        state_d     = WLOCK;
      end
      WLOCK: begin
        counter_we  = 1'b1;
        counter_ch  = g_ch;
        counter_val = g_val;
        state_d     = DONE;
      end
      DONE: begin
        bus.ack = 3'b001 << g_idx;
        bus.err = g_err;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q != IDLE);

  // Grant capture, round-robin pointer and shadow control word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 2'd0;
      g_idx  <= 2'd0;
      g_ch   <= 2'd0;
      g_mode <= 2'd0;
      g_val  <= 32'd0;
      g_err  <= 1'b0;
      shadow <= CTRL_INIT;
    end else begin
      if (state_q == IDLE && gnt_valid) begin
        g_idx  <= gnt_idx;
        g_ch   <= gnt_ch;
        g_mode <= gnt_mode;
        g_val  <= gnt_val;
        g_err  <= (gnt_ch == 2'd3);
        rr_ptr <= inc3(gnt_idx);
      end
      if (state_q == WCTRL) shadow <= shadow_new;
    end
  end

  logic [2:0] sync_q [SYNC_STAGES];
  logic [2:0] sync_prev;
  logic [2:0] tc_rise;
  logic [2:0] wlock_clr;

  assign tc_rise   = sync_q[SYNC_STAGES-1] & ~sync_prev;
  assign wlock_clr = (state_q == WLOCK) ? (3'b001 << g_ch) : 3'b000;

  // Synchronise the foreign-domain OUT bits and remember the last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b000;
      sync_prev <= 3'b000;
    end else begin
      sync_q[0] <= {counter2_OUT, counter1_OUT, counter0_OUT};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sync_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  // Sticky flags: a rising edge wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tc_flag <= 3'b000;
    else     tc_flag <= (tc_flag & ~(tc_clr | wlock_clr)) | tc_rise;
  end

  assign irq = |tc_flag;

endmodule

// File: tb/tb_counter_cfg_sched.sv
// Directed bench for counter_cfg_sched: sequencing, shadow merge,
// round-robin order, rejected channel, tc flags and mid-sequence reset.
module tb_counter_cfg_sched;

  logic        clk;
  logic        rst;
  logic        counter_we;
  logic [1:0]  counter_ch;
  logic [31:0] counter_val;
  logic        counter0_OUT, counter1_OUT, counter2_OUT;
  logic [2:0]  tc_flag;
  logic [2:0]  tc_clr;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;

  counter_cfg_sched_if bus_if ();

  counter_cfg_sched #(.SYNC_STAGES(2), .CTRL_INIT(24'h000000)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_if),
    .counter_we   (counter_we),
    .counter_ch   (counter_ch),
    .counter_val  (counter_val),
    .counter0_OUT (counter0_OUT),
    .counter1_OUT (counter1_OUT),
    .counter2_OUT (counter2_OUT),
    .tc_flag      (tc_flag),
    .tc_clr       (tc_clr),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [1:0] ch, input logic [1:0] mode, input logic [31:0] val);
    bus_if.req_ch[2*r +: 2]   = ch;
    bus_if.req_mode[2*r +: 2] = mode;
    bus_if.req_val[32*r +: 32] = val;
  endtask

  // One accepted sequence from the current cycle: WCTRL, WLOCK, DONE.
  task automatic seq(input string tag, input logic [31:0] ctrl, input logic [1:0] ch,
                     input logic [31:0] val, input logic [2:0] ack);
    tick();
    chk({tag, "_wctrl_we"}, counter_we, 1);
    chk({tag, "_wctrl_ch"}, counter_ch, 3);
    chk({tag, "_wctrl_val"}, counter_val, ctrl);
    chk({tag, "_wctrl_busy"}, bus_if.busy, 1);
    tick();
    chk({tag, "_wlock_we"}, counter_we, 1);
    chk({tag, "_wlock_ch"}, counter_ch, ch);
    chk({tag, "_wlock_val"}, counter_val, val);
    tick();
    chk({tag, "_done_ack"}, bus_if.ack, ack);
    chk({tag, "_done_err"}, bus_if.err, 0);
    chk({tag, "_done_we"}, counter_we, 0);
    chk({tag, "_done_val"}, counter_val, 0);
  endtask

  logic [2:0]  exp_ack [4];
  logic [1:0]  exp_ch  [4];
  logic [31:0] exp_val [4];
  logic [31:0] exp_ctl [4];

  initial begin
    rst = 1'b1;
    bus_if.req = 3'b000;
    bus_if.req_ch = '0;
    bus_if.req_mode = '0;
    bus_if.req_val = '0;
    counter0_OUT = 1'b0;
    counter1_OUT = 1'b0;
    counter2_OUT = 1'b0;
    tc_clr = 3'b000;
    tick();
    tick();
    chk("rst_ack", bus_if.ack, 0);
    chk("rst_err", bus_if.err, 0);
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_we", counter_we, 0);
    chk("rst_ch", counter_ch, 0);
    chk("rst_val", counter_val, 0);
    chk("rst_tc", tc_flag, 0);
    chk("rst_irq", irq, 0);
    rst = 1'b0;
    tick();

    // requester 0: ch0 reload, value 100
    set_req(0, 2'd0, 2'b01, 32'd100);
    bus_if.req = 3'b001;
    seq("r0", 32'h00000002, 2'd0, 32'd100, 3'b001);
    bus_if.req = 3'b000;
    tick();
    chk("r0_idle_busy", bus_if.busy, 0);

    // requester 1: ch2 square, ch0 field must survive
    set_req(1, 2'd2, 2'b10, 32'h00001234);
    bus_if.req = 3'b010;
    seq("r1", 32'h00040002, 2'd2, 32'h00001234, 3'b010);
    bus_if.req = 3'b000;
    tick();

    // requester 2 asks for channel 3: rejected, no writes
    set_req(2, 2'd3, 2'b00, 32'hDEADBEEF);
    bus_if.req = 3'b100;
    tick();
    chk("rej_ack", bus_if.ack, 3'b100);
    chk("rej_err", bus_if.err, 1);
    chk("rej_we", counter_we, 0);
    bus_if.req = 3'b000;
    tick();
    chk("rej_idle_we", counter_we, 0);
    chk("rej_idle_busy", bus_if.busy, 0);

    // all three held: grants 0,1,2,0 with acks four cycles apart
    set_req(0, 2'd0, 2'b11, 32'h0000A0A0);
    set_req(1, 2'd1, 2'b10, 32'h0000B1B1);
    set_req(2, 2'd2, 2'b01, 32'h0000C2C2);
    exp_ack[0] = 3'b001; exp_ch[0] = 2'd0; exp_val[0] = 32'h0000A0A0; exp_ctl[0] = 32'h00040006;
    exp_ack[1] = 3'b010; exp_ch[1] = 2'd1; exp_val[1] = 32'h0000B1B1; exp_ctl[1] = 32'h00040406;
    exp_ack[2] = 3'b100; exp_ch[2] = 2'd2; exp_val[2] = 32'h0000C2C2; exp_ctl[2] = 32'h00020406;
    exp_ack[3] = 3'b001; exp_ch[3] = 2'd0; exp_val[3] = 32'h0000A0A0; exp_ctl[3] = 32'h00020406;
    bus_if.req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      seq($sformatf("rr%0d", g), exp_ctl[g], exp_ch[g], exp_val[g], exp_ack[g]);
      if (g == 3) bus_if.req = 3'b000;
      tick();
      chk($sformatf("rr%0d_idle_busy", g), bus_if.busy, 0);
    end

    // ch1 OUT rises: flag after SYNC_STAGES+1 edges, then cleared
    counter1_OUT = 1'b1;
    tick();
    tick();
    chk("tc1_early", tc_flag, 3'b000);
    tick();
    chk("tc1_set", tc_flag, 3'b010);
    chk("tc1_irq", irq, 1);
    tc_clr = 3'b010;
    tick();
    tc_clr = 3'b000;
    chk("tc1_clr", tc_flag, 3'b000);
    chk("tc1_irq_clr", irq, 0);
    tick();
    chk("tc1_no_reset", tc_flag, 3'b000);

    // ch0 rising edge and tc_clr[0] in the same cycle: set wins
    counter0_OUT = 1'b1;
    tick();
    tick();
    tc_clr = 3'b001;
    tick();
    tc_clr = 3'b000;
    chk("tc0_set_wins", tc_flag, 3'b001);
    tc_clr = 3'b001;
    tick();
    tc_clr = 3'b000;
    chk("tc0_clr", tc_flag, 3'b000);

    // ch2 flag set, then cleared by a WLOCK write to channel 2
    counter2_OUT = 1'b1;
    tick();
    tick();
    tick();
    chk("tc2_set", tc_flag, 3'b100);
    chk("tc2_irq", irq, 1);
    set_req(1, 2'd2, 2'b00, 32'd7);
    bus_if.req = 3'b010;
    tick();
    chk("wl_ctrl", counter_val, 32'h00000406);
    tick();
    chk("wl_ch", counter_ch, 2);
    chk("wl_tc_before", tc_flag, 3'b100);
    tick();
    chk("wl_ack", bus_if.ack, 3'b010);
    chk("wl_tc_after", tc_flag, 3'b000);
    chk("wl_irq", irq, 0);
    bus_if.req = 3'b000;
    tick();

    // reset during WLOCK: everything drops, no ack
    counter0_OUT = 1'b0;
    counter1_OUT = 1'b0;
    counter2_OUT = 1'b0;
    set_req(2, 2'd1, 2'b01, 32'h00000099);
    bus_if.req = 3'b100;
    tick();
    chk("mr_ctrl", counter_val, 32'h00000206);
    tick();
    chk("mr_wlock_ch", counter_ch, 1);
    rst = 1'b1;
    #1;
    chk("mr_we", counter_we, 0);
    chk("mr_ch", counter_ch, 0);
    chk("mr_val", counter_val, 0);
    chk("mr_busy", bus_if.busy, 0);
    bus_if.req = 3'b000;
    tick();
    chk("mr_no_ack", bus_if.ack, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("mr_after_ack", bus_if.ack, 0);

    // fresh sequence uses a zero-based shadow and rr_ptr=0
    set_req(0, 2'd1, 2'b11, 32'h00000ABC);
    set_req(2, 2'd2, 2'b11, 32'h00000001);
    bus_if.req = 3'b101;
    seq("post", 32'h00000600, 2'd1, 32'h00000ABC, 3'b001);
    bus_if.req = 3'b000;
    tick();
    chk("post_idle", bus_if.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
